// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin multiplexing arbiter.
// Imported by the interface, the priority picker and the top level.
package mux_arb_pkg;

  localparam int DEFAULT_N     = 4;
  localparam int DEFAULT_WIDTH = 8;

  // Next requester index in the rotation, wrapping from n-1 back to 0.
  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Bundle of requester-side and downstream-side signals of the arbiter.
// master = requesters plus downstream sink, slave = the arbiter itself.
interface mux_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]            req_valid;
  logic [N-1:0][WIDTH-1:0] req_data;
  logic [N-1:0]            req_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [IDX_W-1:0]        out_sel;
  logic                    out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin search: first requester after ptr, wrapping modulo N.
module rr_priority_pick
  import mux_arb_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  int cur;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    grant_valid = 1'b0;
    grant_idx   = '0;
    cur         = int'(ptr);
    for (int k = 0; k < N; k++) begin
      cur = next_idx(cur, N);
      if (!grant_valid && req[cur]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cur);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// N:1 round-robin arbiter feeding a single registered valid/ready output stage.
// Holds the priority pointer, the output register and the data mux.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  mux_rr_arbiter_if.slave   bus
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             load_en;
  logic             handshake;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [IDX_W-1:0] out_sel_q;

  rr_priority_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req         (bus.req_valid),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // The register can take a new word when empty or when it drains this cycle.
  assign load_en   = !out_valid_q || bus.out_ready;
  assign handshake = grant_valid && load_en && !rst;

  assign bus.req_ready = handshake ? (N'(1) << grant_idx) : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr         <= IDX_W'(N - 1);
    end else if (handshake) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.req_data[grant_idx];
      out_sel_q   <= grant_idx;
      ptr         <= grant_idx;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with N=4, WIDTH=8.
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int N     = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  mux_rr_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

  mux_rr_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge; observations 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] dval(input int i);
    return WIDTH'(8'h11 * (i + 1));
  endfunction

  task automatic load_all_data();
    for (int i = 0; i < N; i++) bus.req_data[i] = dval(i);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    load_all_data();
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready);
      end
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_sel !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got v=%b d=%h s=%0d want v=0 d=00 s=0",
                 bus.out_valid, bus.out_data, bus.out_sel);
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL reset_first_grant: got %b want 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'h0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 8'h11) begin
      n_fail++;
      $display("FAIL reset_first_word: got v=%b d=%h s=%0d want v=1 d=11 s=0",
               bus.out_valid, bus.out_data, bus.out_sel);
    end
    tick();
  endtask

  task automatic test_single();
    bus.req_valid = 4'b0100;
    bus.req_data[2] = 8'hA5;
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_req_ready: got %b want 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL single_word: got v=%b d=%h s=%0d want v=1 d=a5 s=2",
               bus.out_valid, bus.out_data, bus.out_sel);
    end
    tick();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'hA5 || bus.out_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL single_drain_hold: got v=%b d=%h s=%0d want v=0 d=a5 s=2",
               bus.out_valid, bus.out_data, bus.out_sel);
    end
  endtask

  task automatic test_round_robin();
    // Fresh reset so the rotation starts at requester 0.
    rst = 1'b1;
    bus.req_valid = 4'h0;
    tick();
    rst = 1'b0;
    load_all_data();
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== (4'b0001 << (k % N))) begin
        n_fail++;
        $display("FAIL rr_req_ready[%0d]: got %b want %b", k, bus.req_ready, 4'b0001 << (k % N));
      end
      tick();
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(k % N) || bus.out_data !== dval(k % N)) begin
        n_fail++;
        $display("FAIL rr_word[%0d]: got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                 k, bus.out_valid, bus.out_data, bus.out_sel, dval(k % N), k % N);
      end
    end
  endtask

  task automatic test_backpressure();
    // Last winner was 3 and its word is held; stall the output.
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_req_ready[%0d]: got %b want 0000", c, bus.req_ready);
      end
      tick();
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd3 || bus.out_data !== dval(3)) begin
        n_fail++;
        $display("FAIL bp_frozen[%0d]: got v=%b d=%h s=%0d want v=1 d=%h s=3",
                 c, bus.out_valid, bus.out_data, bus.out_sel, dval(3));
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL bp_resume_grant: got %b want 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'h0;
    #1;
    n_checks++;
    if (bus.out_sel !== 2'd0 || bus.out_data !== dval(0)) begin
      n_fail++;
      $display("FAIL bp_resume_word: got d=%h s=%0d want d=%h s=0", bus.out_data, bus.out_sel, dval(0));
    end
    tick();
  endtask

  task automatic test_wrap_skip();
    logic [N-1:0] exp_ready [3];
    logic [1:0]   exp_sel   [3];
    exp_ready = '{4'b0010, 4'b1000, 4'b0010};
    exp_sel   = '{2'd1, 2'd3, 2'd1};
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b1000;
    tick();
    #1;
    n_checks++;
    if (bus.out_sel !== 2'd3) begin
      n_fail++; $display("FAIL wrap_setup_sel: got %0d want 3", bus.out_sel);
    end
    bus.req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== exp_ready[k]) begin
        n_fail++; $display("FAIL wrap_req_ready[%0d]: got %b want %b", k, bus.req_ready, exp_ready[k]);
      end
      tick();
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== exp_sel[k] || bus.out_data !== dval(int'(exp_sel[k]))) begin
        n_fail++;
        $display("FAIL wrap_word[%0d]: got v=%b d=%h s=%0d want v=1 s=%0d",
                 k, bus.out_valid, bus.out_data, bus.out_sel, exp_sel[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Word from requester 1 is held; stall, then reset.
    bus.out_ready = 1'b0;
    bus.req_valid = 4'h0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre_valid: got %b want 1", bus.out_valid);
    end
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL mid_rst_req_ready: got %b want 0000", bus.req_ready);
    end
    tick();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_rst_cleared: got v=%b d=%h s=%0d want v=0 d=00 s=0",
               bus.out_valid, bus.out_data, bus.out_sel);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL mid_ptr_restart: got %b want 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'h0;
    #1;
    n_checks++;
    if (bus.out_sel !== 2'd0 || bus.out_data !== dval(0)) begin
      n_fail++; $display("FAIL mid_first_word: got d=%h s=%0d want d=%h s=0", bus.out_data, bus.out_sel, dval(0));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
